// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared types and constants for the sequential multiplier control.
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Default operand width; the product is twice this width.
    localparam int DEFAULT_WIDTH = 16;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter_cnt
// Purpose  : Iteration counter with synchronous clear/enable and a flag that
//            is high while the count equals TC_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module mul_iter_cnt #(
    parameter int CW     = 4,
    parameter int TC_VAL = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] C_TC = CW'(TC_VAL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == C_TC);

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_ctrl
// Purpose  : Control FSM for an external shift-add multiplier datapath.
//            Accepts operands, loads the datapath, waits WIDTH-1 run cycles,
//            captures the product and holds it until the consumer takes it.
//            Optional feature macro: MUL_SEQ_CTRL_SIGNED_EN (two's complement
//            operands; magnitudes are sent to the datapath and the captured
//            product is negated when the operand signs differ).
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               mul_write,
    output logic [WIDTH-1:0]   mul_mcand,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res
);

    // Counter only has to reach WIDTH-2, so log2(WIDTH) bits suffice.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [2*WIDTH-1:0] prod_in;

`ifdef MUL_SEQ_CTRL_SIGNED_EN
    logic sign_q, sign_d;

    // Magnitudes of the incoming operands; the most negative value maps to
    // itself, which read as unsigned is the correct magnitude.
    always_comb begin
        a_in    = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
        b_in    = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
        prod_in = sign_q ? (~mul_prod + 1'b1) : mul_prod;
        sign_d  = sign_q;
        if (state_q == IDLE && start_valid) begin
            sign_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end
    end

    // Result sign register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end
`else
    // Unsigned operation: operands and product pass straight through.
    always_comb begin
        a_in    = op_a;
        b_in    = op_b;
        prod_in = mul_prod;
    end
`endif

    // Next-state, operand capture and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = CAP;
                end
            end
            CAP: begin
                res_d   = prod_in;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    mul_iter_cnt #(
        .CW     (CW),
        .TC_VAL (WIDTH - 2)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    assign start_ready = (state_q == IDLE);
    assign mul_write   = (state_q == LOAD);
    assign res_valid   = (state_q == DONE);
    assign mul_mcand   = a_q;
    assign mul_b       = b_q;
    assign res         = res_q;

endmodule
`default_nettype wire
